ifu_fetch_ctrl: RTL and testbench

- Instruction-fetch initiator: owns the program counter and drives the ifu_rd_req / ifu_rd_addr / ifu_rd_data read interface into the memory model or RAM.
- Buffers returned 12-bit words (octal opcode in bits [11:9]) and presents them, tagged with their address, to the decoder over a valid/ready handshake.
- Supports redirect (branch/jump) with flush, and a halt input.
- Sits between the memory responder and the decode stage.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fetch_ctrl_if.sv | 20 ++
 rtl/ifu_fetch_buf.sv | 44 ++++
 rtl/ifu_fetch_ctrl.sv | 60 ++++++
 tb/tb_ifu_fetch_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, types and reset address for the instruction-fetch unit
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
package ifu_pkg;
  typedef logic [`ADDR_WIDTH-1:0] ifu_addr_t;
  typedef logic [`DATA_WIDTH-1:0] ifu_word_t;
  typedef struct packed {
    ifu_word_t data;
    ifu_addr_t addr;
  } ifu_entry_t;
  localparam ifu_addr_t IFU_RESET_PC = 'o200;
endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// ifu_fetch_ctrl_if: memory read bus plus decoder valid/ready handshake
interface ifu_fetch_ctrl_if
  import ifu_pkg::*;
  ();
  logic      ifu_rd_req;
  ifu_addr_t ifu_rd_addr;
  ifu_word_t ifu_rd_data;
  logic      instr_valid;
  logic      instr_ready;
  ifu_word_t instr_data;
  ifu_addr_t instr_pc;
  modport master (
    output ifu_rd_req, ifu_rd_addr, instr_valid, instr_data, instr_pc,
    input  ifu_rd_data, instr_ready
  );
  modport slave (
    input  ifu_rd_req, ifu_rd_addr, instr_valid, instr_data, instr_pc,
    output ifu_rd_data, instr_ready
  );
endinterface

// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: 2-entry FIFO of fetched words; flush beats push
module ifu_fetch_buf
  import ifu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  ifu_entry_t entry_i,
  output logic [1:0] count_o,
  output ifu_entry_t head_o
);
  ifu_entry_t mem_q [2];
  logic       wp_q, rp_q;
  logic [1:0] count_q;
  logic       pop;
  assign pop     = pop_i && count_q != 2'd0;
  assign count_o = count_q;
  assign head_o  = mem_q[rp_q];
  // Storage and pointers; a flush empties the FIFO and drops any incoming word
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= entry_i;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop};
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && !pop && count_q == 2'd2));
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: program counter, credit-checked read issue and response buffering
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter ifu_addr_t RESET_PC = IFU_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  ifu_fetch_ctrl_if.master        bus,
  input  logic                    redirect_en,
  input  ifu_addr_t               redirect_addr,
  input  logic                    halt,
  output logic                    ifu_idle
);
  ifu_addr_t  pc_q, pc_d, paddr_q, paddr_d;
  logic       pend_q, deq, issue;
  logic [1:0] count;
  logic [2:0] credit;
  ifu_entry_t head;
  // Issue only when every in-flight response is guaranteed a buffer slot
  always_comb begin
    deq     = bus.instr_valid && bus.instr_ready;
    credit  = {1'b0, count} + {2'b0, pend_q} - {2'b0, deq};
    issue   = !rst && !halt && !redirect_en && credit < 3'd2;
    pc_d    = redirect_en ? redirect_addr : issue ? pc_q + ifu_addr_t'(1) : pc_q;
    paddr_d = issue ? pc_q : paddr_q;
  end
  // PC and the single outstanding-read tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      paddr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= issue;
      paddr_q <= paddr_d;
    end
  end
  ifu_fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pend_q && !redirect_en),
    .pop_i   (deq),
    .flush_i (redirect_en),
    .entry_i ('{data: bus.ifu_rd_data, addr: paddr_q}),
    .count_o (count),
    .head_o  (head)
  );
  assign bus.ifu_rd_req  = issue;
  assign bus.ifu_rd_addr = pc_q;
  assign bus.instr_valid = count != 2'd0;
  assign bus.instr_data  = head.data;
  assign bus.instr_pc    = head.addr;
  assign ifu_idle        = !pend_q && count == 2'd0;
  a_credit: assert property (@(posedge clk) disable iff (rst)
    bus.ifu_rd_req |-> credit < 3'd2);
  a_seq: assert property (@(posedge clk) disable iff (rst)
    bus.ifu_rd_req && pend_q |-> pc_q == paddr_q + ifu_addr_t'(1));
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed vector table plus randomized run against a queue model
module tb_ifu_fetch_ctrl;
  import ifu_pkg::*;
  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      redirect_en = 1'b0;
  logic      halt = 1'b0;
  ifu_addr_t redirect_addr = '0;
  logic      ifu_idle;
  int        vectors = 0;
  int        miscompares = 0;
  ifu_fetch_ctrl_if bus();
  ifu_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .ifu_idle      (ifu_idle)
  );
  always #5 clk = ~clk;
  function automatic ifu_word_t memf(ifu_addr_t a);
    return a ^ 12'o5252;
  endfunction
  always @(posedge clk) if (bus.ifu_rd_req) bus.ifu_rd_data <= memf(bus.ifu_rd_addr);
  ifu_addr_t m_pc = IFU_RESET_PC;
  bit        m_pend = 1'b0;
  ifu_addr_t m_paddr = '0;
  ifu_addr_t m_q[$];
  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask
  function automatic bit m_deq();
    return m_q.size() > 0 && bus.instr_ready;
  endfunction
  function automatic bit m_req();
    return !rst && !halt && !redirect_en && (m_q.size() + int'(m_pend) - int'(m_deq()) < 2);
  endfunction
  task automatic model_check();
    chk("m_req", int'(bus.ifu_rd_req), int'(m_req()));
    chk("m_addr", int'(bus.ifu_rd_addr), int'(m_pc));
    chk("m_valid", int'(bus.instr_valid), int'(m_q.size() > 0));
    chk("m_idle", int'(ifu_idle), int'(!m_pend && m_q.size() == 0));
    if (m_q.size() > 0) begin
      chk("m_ipc", int'(bus.instr_pc), int'(m_q[0]));
      chk("m_idata", int'(bus.instr_data), int'(memf(m_q[0])));
    end
  endtask
  task automatic model_update();
    bit d, r;
    if (rst) begin
      m_pc = IFU_RESET_PC;
      m_pend = 1'b0;
      m_q.delete();
    end else begin
      d = m_deq();
      r = m_req();
      if (d) void'(m_q.pop_front());
      if (redirect_en) m_q.delete();
      else if (m_pend) m_q.push_back(m_paddr);
      m_paddr = m_pc;
      m_pend = r;
      m_pc = redirect_en ? redirect_addr : r ? m_pc + ifu_addr_t'(1) : m_pc;
    end
  endtask
  task automatic step();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  typedef struct {
    bit rst, halt, rdy, redir;
    ifu_addr_t raddr;
    bit req;
    ifu_addr_t addr;
    bit valid;
    ifu_addr_t ipc;
    bit idle;
  } vec_t;
  function automatic vec_t mk(bit r, bit h, bit y, bit d, ifu_addr_t ra,
                              bit q, ifu_addr_t a, bit v, ifu_addr_t p, bit i);
    return '{r, h, y, d, ra, q, a, v, p, i};
  endfunction
  vec_t tbl[36];
  initial begin
    tbl[0]  = mk(1,0,1,0,0,      0,'o200, 0,0,1);
    tbl[1]  = mk(0,0,1,0,0,      1,'o200, 0,0,1);
    tbl[2]  = mk(0,0,1,0,0,      1,'o201, 0,0,0);
    tbl[3]  = mk(0,0,1,0,0,      1,'o202, 1,'o200,0);
    tbl[4]  = mk(0,0,1,0,0,      1,'o203, 1,'o201,0);
    for (int i = 5; i <= 10; i++) tbl[i] = mk(0,0,0,0,0, 0,'o204, 1,'o202,0);
    tbl[11] = mk(0,0,1,0,0,      1,'o204, 1,'o202,0);
    tbl[12] = mk(0,0,1,0,0,      1,'o205, 1,'o203,0);
    tbl[13] = mk(0,0,1,1,'o4000, 0,'o206, 1,'o204,0);
    tbl[14] = mk(0,0,1,0,0,      1,'o4000,0,0,1);
    tbl[15] = mk(0,0,1,0,0,      1,'o4001,0,0,0);
    tbl[16] = mk(0,0,1,0,0,      1,'o4002,1,'o4000,0);
    tbl[17] = mk(0,0,1,1,'o7776, 0,'o4003,1,'o4001,0);
    tbl[18] = mk(0,0,1,0,0,      1,'o7776,0,0,1);
    tbl[19] = mk(0,0,1,0,0,      1,'o7777,0,0,0);
    tbl[20] = mk(0,0,1,0,0,      1,'o0000,1,'o7776,0);
    tbl[21] = mk(0,0,1,0,0,      1,'o0001,1,'o7777,0);
    tbl[22] = mk(0,0,1,0,0,      1,'o0002,1,'o0000,0);
    tbl[23] = mk(0,0,1,0,0,      1,'o0003,1,'o0001,0);
    tbl[24] = mk(0,0,1,1,'o0207, 0,'o0004,1,'o0002,0);
    tbl[25] = mk(0,0,1,0,0,      1,'o0207,0,0,1);
    tbl[26] = mk(0,1,1,0,0,      0,'o0210,0,0,0);
    tbl[27] = mk(0,1,1,0,0,      0,'o0210,1,'o0207,0);
    tbl[28] = mk(0,1,1,0,0,      0,'o0210,0,0,1);
    tbl[29] = mk(0,1,1,0,0,      0,'o0210,0,0,1);
    tbl[30] = mk(0,0,1,0,0,      1,'o0210,0,0,1);
    tbl[31] = mk(0,0,1,0,0,      1,'o0211,0,0,0);
    tbl[32] = mk(1,0,0,0,0,      0,'o0212,1,'o0210,0);
    tbl[33] = mk(0,0,1,0,0,      1,'o0200,0,0,1);
    tbl[34] = mk(0,0,1,0,0,      1,'o0201,0,0,0);
    tbl[35] = mk(0,0,1,0,0,      1,'o0202,1,'o0200,0);
    bus.instr_ready = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int i = 0; i < 36; i++) begin
      rst = tbl[i].rst;
      halt = tbl[i].halt;
      bus.instr_ready = tbl[i].rdy;
      redirect_en = tbl[i].redir;
      redirect_addr = tbl[i].raddr;
      #1;
      chk($sformatf("r%0d_req", i), int'(bus.ifu_rd_req), int'(tbl[i].req));
      chk($sformatf("r%0d_addr", i), int'(bus.ifu_rd_addr), int'(tbl[i].addr));
      chk($sformatf("r%0d_valid", i), int'(bus.instr_valid), int'(tbl[i].valid));
      chk($sformatf("r%0d_idle", i), int'(ifu_idle), int'(tbl[i].idle));
      if (tbl[i].valid) begin
        chk($sformatf("r%0d_ipc", i), int'(bus.instr_pc), int'(tbl[i].ipc));
        chk($sformatf("r%0d_idata", i), int'(bus.instr_data), int'(memf(tbl[i].ipc)));
      end
      if (i == 1) begin
        chk("rst_idata", int'(bus.instr_data), 0);
        chk("rst_ipc", int'(bus.instr_pc), 0);
      end
      step();
    end
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(99) == 0;
      halt = $urandom_range(4) == 0;
      bus.instr_ready = $urandom_range(4) < 3;
      redirect_en = $urandom_range(19) == 0;
      redirect_addr = $urandom_range(3) == 0 ? ifu_addr_t'(12'o7775 + $urandom_range(3))
                                             : ifu_addr_t'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
